// File: rtl/svm_mac_engine.sv
// svm_mac_engine
// Sequential binary-SVM evaluator (responder side of the one-vs-one picker
// handshake). On start the feature vector is latched. Then, for each pairwise
// classifier the picker presents, the engine computes
//   score = bia + sum_i features[i] * weight[i]
// one feature per cycle. It reports the sign as w_class together with a
// one-cycle svmready strobe and re-arms for the next classifier until halt.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   start     begin a classification (honoured in IDLE only)
//   features  N_features unsigned features, feature i at [i*inWidth +: inWidth]
//   weight    N_features signed weights, weight i at [i*weightWidth +: weightWidth]
//   bia       signed bias of the current pairwise classifier
//   halt      picker done/abort; honoured in LOAD and MAC
//   w_class   1 = second class of the pair wins (score >= 0)
//   svmready  one-cycle decision strobe
//   busy      high whenever the engine is not idle
//   score     signed score of the last decision, held until the next one
module svm_mac_engine #(
  parameter int N_features  = 16,
  parameter int inWidth     = 4,
  parameter int weightWidth = 8,
  parameter int biasWidth   = 16,
  parameter int accWidth    = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [inWidth*N_features-1:0]       features,
  input  logic [weightWidth*N_features-1:0]   weight,
  input  logic signed [biasWidth-1:0]         bia,
  input  logic                                halt,
  output logic                                w_class,
  output logic                                svmready,
  output logic                                busy,
  output logic signed [accWidth-1:0]          score
);

  localparam int IdxW    = (N_features > 1) ? $clog2(N_features) : 1;
  localparam int ProdW   = inWidth + 1 + weightWidth;
  localparam int SumW    = ProdW + $clog2(N_features);
  localparam int MinAccW = ((biasWidth > SumW) ? biasWidth : SumW) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_features - 1);

  // The accumulator must hold the worst-case dot product plus bias without
  // wrapping, since there is no saturation.
  generate
    if (accWidth < MinAccW) begin : g_acc_width_check
      $error("svm_mac_engine: accWidth too small for the chosen widths");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    MAC    = 2'd2,
    DECIDE = 2'd3
  } state_t;

  state_t                          state_q;
  logic [inWidth*N_features-1:0]   feat_q;
  logic signed [accWidth-1:0]      acc_q;
  logic [IdxW-1:0]                 idx_q;

  // Unpacked views of the latched features and the live weights so the
  // per-cycle operand select is a plain array index.
  logic [inWidth-1:0]              feat_arr [N_features];
  logic signed [weightWidth-1:0]   w_arr    [N_features];

  genvar gi;
  generate
    for (gi = 0; gi < N_features; gi++) begin : g_unpack
      assign feat_arr[gi] = feat_q[gi*inWidth +: inWidth];
      assign w_arr[gi]    = weight[gi*weightWidth +: weightWidth];
    end
  endgenerate

  // Features are unsigned: a zero is prepended so the signed multiply treats
  // them as non-negative.
  logic signed [inWidth:0]         feat_s;
  logic signed [ProdW-1:0]         prod;
  logic signed [accWidth-1:0]      prod_ext;
  logic signed [accWidth-1:0]      bias_ext;
  logic signed [accWidth-1:0]      acc_sum;

  assign feat_s   = $signed({1'b0, feat_arr[idx_q]});
  assign prod     = feat_s * w_arr[idx_q];
  assign prod_ext = {{(accWidth-ProdW){prod[ProdW-1]}}, prod};
  assign bias_ext = {{(accWidth-biasWidth){bia[biasWidth-1]}}, bia};
  assign acc_sum  = acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      feat_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      w_class  <= 1'b0;
      svmready <= 1'b0;
      busy     <= 1'b0;
      score    <= '0;
    end else begin
      svmready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            feat_q  <= features;
            state_q <= LOAD;
            busy    <= 1'b1;
          end
        end

        LOAD: begin
          if (halt) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            acc_q   <= bias_ext;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end

        MAC: begin
          if (halt) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            acc_q <= acc_sum;
            if (idx_q == LastIdx) begin
              // Decision is registered on entry to DECIDE so that score,
              // w_class and the strobe all appear in the same cycle.
              idx_q    <= '0;
              state_q  <= DECIDE;
              score    <= acc_sum;
              w_class  <= ~acc_sum[accWidth-1];
              svmready <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        DECIDE: begin
          // Never held: a halt raised by the picker is seen in LOAD.
          state_q <= LOAD;
        end

        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svm_mac_engine.sv
module tb_svm_mac_engine;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int WW = 8;
  localparam int BW = 16;
  localparam int AW = 24;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [IW*N-1:0]        features;
  logic [WW*N-1:0]        weight;
  logic signed [BW-1:0]   bia;
  logic                   halt;
  logic                   w_class;
  logic                   svmready;
  logic                   busy;
  logic signed [AW-1:0]   score;

  svm_mac_engine #(
    .N_features (N),
    .inWidth    (IW),
    .weightWidth(WW),
    .biasWidth  (BW),
    .accWidth   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .features(features),
    .weight  (weight),
    .bia     (bia),
    .halt    (halt),
    .w_class (w_class),
    .svmready(svmready),
    .busy    (busy),
    .score   (score)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Current classifier / sample as plain integers
  int fi [N];
  int wi [N];
  int bi;

  // Picker tables: weights and bias per (first, second) class pair
  int wtab [10][10][N];
  int btab [10][10];

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: got %0d", tag, obs);
    end
  endtask

  // Reference: score = bias + dot(features, weights), plain integer maths
  function automatic int ref_score();
    int s;
    s = bi;
    for (int i = 0; i < N; i++) s += fi[i] * wi[i];
    return s;
  endfunction

  task automatic drive_vectors();
    for (int i = 0; i < N; i++) begin
      features[i*IW +: IW] = fi[i][IW-1:0];
      weight[i*WW +: WW]   = wi[i][WW-1:0];
    end
    bia = bi[BW-1:0];
  endtask

  task automatic randomize_sample();
    for (int i = 0; i < N; i++) begin
      fi[i] = int'($urandom_range(0, 15));
      wi[i] = int'($urandom_range(0, 255)) - 128;
    end
    bi = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges from now until svmready is seen (bounded).
  task automatic wait_ready(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (svmready === 1'b1) break;
    end
    check({tag, "_ready_seen"}, longint'(svmready), 1);
  endtask

  // Called in the DECIDE cycle: raise halt in the following LOAD cycle.
  task automatic stop_in_load(input string tag);
    @(posedge clk);
    #1 halt = 1'b1;
    @(negedge clk);
    check({tag, "_busy_in_load"}, longint'(busy), 1);
    @(posedge clk);
    #1 halt = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_halt"}, longint'(busy), 0);
    check({tag, "_no_strobe_after_halt"}, longint'(svmready), 0);
  endtask

  task automatic run_one(input string tag);
    int exp_s;
    int lat;
    exp_s = ref_score();
    drive_vectors();
    pulse_start();
    check({tag, "_busy"}, longint'(busy), 1);
    wait_ready(tag, lat);
    check({tag, "_latency"}, lat, N + 1);
    check({tag, "_score"}, longint'(score), exp_s);
    check({tag, "_class"}, longint'(w_class), (exp_s >= 0) ? 1 : 0);
    stop_in_load(tag);
  endtask

  task automatic count_strobes(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (svmready === 1'b1) n++;
    end
    check({tag, "_strobes"}, n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_s;
    int cur;
    int golden;

    rst      = 1'b1;
    start    = 1'b0;
    halt     = 1'b0;
    features = '0;
    weight   = '0;
    bia      = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", longint'(busy), 0);
    check("reset_ready", longint'(svmready), 0);
    check("reset_class", longint'(w_class), 0);
    check("reset_score", longint'(score), 0);
    rst = 1'b0;

    // halt in IDLE is ignored and nothing starts without start
    halt = 1'b1;
    repeat (2) @(negedge clk);
    halt = 1'b0;
    check("idle_halt_busy", longint'(busy), 0);

    // Threshold: score exactly 0 -> second class
    for (int i = 0; i < N; i++) begin fi[i] = 1; wi[i] = 1; end
    bi = -16;
    run_one("thr0");

    // Threshold: score -1 -> first class
    bi = -17;
    run_one("thrm1");

    // Extreme magnitude, must not wrap
    for (int i = 0; i < N; i++) begin fi[i] = 15; wi[i] = -128; end
    bi = -32768;
    run_one("extreme");

    for (int t = 0; t < 4; t++) begin
      randomize_sample();
      run_one($sformatf("rand%0d", t));
    end

    // Full one-vs-one run: winner so far vs next challenger, 9 decisions
    randomize_sample();
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++) begin
        for (int i = 0; i < N; i++) wtab[a][b][i] = int'($urandom_range(0, 255)) - 128;
        btab[a][b] = int'($urandom_range(0, 20000)) - 10000;
      end
    golden = 0;
    for (int c = 1; c < 10; c++) begin
      for (int i = 0; i < N; i++) wi[i] = wtab[golden][c][i];
      bi = btab[golden][c];
      if (ref_score() >= 0) golden = c;
    end
    cur = 0;
    for (int i = 0; i < N; i++) wi[i] = wtab[0][1][i];
    bi = btab[0][1];
    drive_vectors();
    pulse_start();
    for (int d = 1; d < 10; d++) begin
      exp_s = ref_score();
      wait_ready($sformatf("ovo%0d", d), lat);
      check($sformatf("ovo%0d_period", d), lat, (d == 1) ? N + 1 : N + 2);
      check($sformatf("ovo%0d_score", d), longint'(score), exp_s);
      check($sformatf("ovo%0d_class", d), longint'(w_class), (exp_s >= 0) ? 1 : 0);
      if (w_class === 1'b1) cur = d;
      if (d < 9) begin
        // DECIDE does not use weight/bias; the next LOAD sees the new pair.
        for (int i = 0; i < N; i++) wi[i] = wtab[cur][d+1][i];
        bi = btab[cur][d+1];
        drive_vectors();
      end
    end
    stop_in_load("ovo_end");
    check("ovo_winner", cur, golden);

    // halt during MAC at idx 5
    randomize_sample();
    drive_vectors();
    pulse_start();
    repeat (6) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_mid_busy", longint'(busy), 0);
    check("halt_mid_ready", longint'(svmready), 0);
    count_strobes("halt_mid", 25);
    randomize_sample();
    run_one("after_halt");

    // Known non-zero score so the reset clearing it is visible
    for (int i = 0; i < N; i++) begin fi[i] = int'($urandom_range(0, 15)); wi[i] = 0; end
    bi = 1000;
    run_one("pre_rst");

    // rst during MAC at idx 5
    randomize_sample();
    drive_vectors();
    pulse_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_ready", longint'(svmready), 0);
    check("rst_mid_class", longint'(w_class), 0);
    check("rst_mid_score", longint'(score), 0);
    count_strobes("rst_mid", 25);
    randomize_sample();
    run_one("after_rst");

    // start held high with features changing during the run
    randomize_sample();
    exp_s = ref_score();
    drive_vectors();
    start = 1'b1;
    @(negedge clk);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      features = {$urandom, $urandom};
      @(negedge clk);
      lat++;
      if (svmready === 1'b1) break;
    end
    start = 1'b0;
    check("spam_ready_seen", longint'(svmready), 1);
    check("spam_latency", lat, N + 1);
    check("spam_score", longint'(score), exp_s);
    check("spam_class", longint'(w_class), (exp_s >= 0) ? 1 : 0);
    stop_in_load("spam");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
